// File: rtl/match_sched.sv
// match_sched: session FSM plus two-lane round-robin match arbiter.
// Ports: slow_clk, reset (async, active-high), start, stop, req_a, req_b;
// outputs gnt_a, gnt_b, enable_count, trade_count[7:0], halt_signal,
// state[1:0].
// Optional feature: define SCHED_COOLDOWN_EN to force COOLDOWN idle
// cycles after every grant.
module match_sched #(
    parameter int MAX_TRADES = 99,
    parameter int COOLDOWN   = 2
) (
    input  logic       slow_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       req_a,
    input  logic       req_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       enable_count,
    output logic [7:0] trade_count,
    output logic       halt_signal,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_OPEN   = 2'b01,
        S_HALTED = 2'b10,
        S_CLOSED = 2'b11
    } state_t;

    if (MAX_TRADES < 1 || MAX_TRADES > 255) begin : g_bad_max
        $error("match_sched: MAX_TRADES out of range 1..255");
    end
    if (COOLDOWN < 1 || COOLDOWN > 15) begin : g_bad_cd
        $error("match_sched: COOLDOWN out of range 1..15");
    end

    localparam logic [7:0] MAX_TC = 8'(MAX_TRADES);

    state_t     st;
    logic       ptr_b;   // 1: lane B granted last, so A wins a tie
    logic       elig_a;
    logic       elig_b;
    logic       pick_a;
    logic       pick_b;
    logic       cd_ok;
    logic       grant;
    logic [7:0] tc_nxt;

    // A lane that holds gnt this cycle is dropping its request,
    // so it cannot be granted again on the next edge.
    always_comb begin
        elig_a = req_a & ~gnt_a;
        elig_b = req_b & ~gnt_b;
        pick_a = elig_a & (~elig_b | ptr_b);
        pick_b = elig_b & (~elig_a | ~ptr_b);
        grant  = (st == S_OPEN) & ~stop & cd_ok
               & (pick_a | pick_b);
        tc_nxt = trade_count + 8'd1;
    end

`ifdef SCHED_COOLDOWN_EN
    logic [3:0] cd_cnt;

    assign cd_ok = (cd_cnt == 4'd0);

    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            cd_cnt <= 4'd0;
        end else if (st != S_OPEN || stop) begin
            cd_cnt <= 4'd0;
        end else if (grant) begin
            // A grant that halts the session also leaves OPEN.
            if (tc_nxt == MAX_TC) begin
                cd_cnt <= 4'd0;
            end else begin
                cd_cnt <= 4'(COOLDOWN);
            end
        end else if (cd_cnt != 4'd0) begin
            cd_cnt <= cd_cnt - 4'd1;
        end
    end
`else
    assign cd_ok = 1'b1;
`endif

    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            st           <= S_IDLE;
            gnt_a        <= 1'b0;
            gnt_b        <= 1'b0;
            enable_count <= 1'b0;
            trade_count  <= 8'd0;
            halt_signal  <= 1'b0;
            ptr_b        <= 1'b1;
        end else begin
            gnt_a        <= 1'b0;
            gnt_b        <= 1'b0;
            enable_count <= 1'b0;
            unique case (st)
                S_IDLE: begin
                    if (start) begin
                        st <= S_OPEN;
                    end
                end
                S_OPEN: begin
                    if (stop) begin
                        st <= S_CLOSED;
                    end else if (grant) begin
                        gnt_a        <= pick_a;
                        gnt_b        <= pick_b;
                        enable_count <= 1'b1;
                        ptr_b        <= pick_b;
                        trade_count  <= tc_nxt;
                        if (tc_nxt == MAX_TC) begin
                            st          <= S_HALTED;
                            halt_signal <= 1'b1;
                        end
                    end
                end
                S_HALTED: begin
                    if (stop) begin
                        st          <= S_CLOSED;
                        halt_signal <= 1'b0;
                    end
                end
                S_CLOSED: begin
                    halt_signal <= 1'b0;
                    if (start) begin
                        st          <= S_OPEN;
                        trade_count <= 8'd0;
                    end
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_match_sched.sv
// tb_match_sched: directed self-checking bench for match_sched.
// Drives a default instance and a MAX_TRADES=3 instance from shared inputs.
module tb_match_sched;

    logic slow_clk = 1'b0;
    logic reset    = 1'b1;
    logic start    = 1'b0;
    logic stop     = 1'b0;
    logic req_a    = 1'b0;
    logic req_b    = 1'b0;

    logic       d_gnt_a, d_gnt_b, d_en, d_halt;
    logic [7:0] d_tc;
    logic [1:0] d_st;
    logic       h_gnt_a, h_gnt_b, h_en, h_halt;
    logic [7:0] h_tc;
    logic [1:0] h_st;

    int n_vec = 0;
    int n_err = 0;

    always #5 slow_clk = ~slow_clk;

    match_sched dut (
        .slow_clk     (slow_clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .req_a        (req_a),
        .req_b        (req_b),
        .gnt_a        (d_gnt_a),
        .gnt_b        (d_gnt_b),
        .enable_count (d_en),
        .trade_count  (d_tc),
        .halt_signal  (d_halt),
        .state        (d_st)
    );

    match_sched #(.MAX_TRADES(3)) dut3 (
        .slow_clk     (slow_clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .req_a        (req_a),
        .req_b        (req_b),
        .gnt_a        (h_gnt_a),
        .gnt_b        (h_gnt_b),
        .enable_count (h_en),
        .trade_count  (h_tc),
        .halt_signal  (h_halt),
        .state        (h_st)
    );

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge slow_clk);
        #1;
    endtask

    task automatic chk_d(input string tag, input logic ga,
                         input logic gb, input logic [7:0] tc,
                         input logic [1:0] st);
        chk({tag, ".gnt_a"}, {7'd0, d_gnt_a}, {7'd0, ga});
        chk({tag, ".gnt_b"}, {7'd0, d_gnt_b}, {7'd0, gb});
        chk({tag, ".en"},    {7'd0, d_en},    {7'd0, ga | gb});
        chk({tag, ".tc"},    d_tc,            tc);
        chk({tag, ".state"}, {6'd0, d_st},    {6'd0, st});
    endtask

    initial begin
        // reset state, no clock edge yet
        #3;
        chk_d("rst", 1'b0, 1'b0, 8'd0, 2'b00);
        chk("rst.halt", {7'd0, d_halt}, 8'd0);
        @(negedge slow_clk);
        reset = 1'b0;

        // stop ignored in IDLE
        stop = 1'b1;
        tick();
        chk("idle_stop.state", {6'd0, d_st}, 8'd0);
        stop = 1'b0;

        // single request on lane A
        start = 1'b1;
        tick();
        chk("open.state", {6'd0, d_st}, 8'd1);
        start = 1'b0;
        req_a = 1'b1;
        tick();
        chk_d("single", 1'b1, 1'b0, 8'd1, 2'b01);
        req_a = 1'b0;
        tick();
        chk_d("single_end", 1'b0, 1'b0, 8'd1, 2'b01);
        tick();

        // stop beats an eligible req_b
        stop  = 1'b1;
        req_b = 1'b1;
        tick();
        chk_d("stop_pri", 1'b0, 1'b0, 8'd1, 2'b11);
        stop  = 1'b0;
        start = 1'b1;
        tick();
        chk_d("reopen", 1'b0, 1'b0, 8'd0, 2'b01);
        start = 1'b0;
        tick();
        chk_d("held_b", 1'b0, 1'b1, 8'd1, 2'b01);
        req_b = 1'b0;
        tick();

        // fresh session for the continuous-request cases
        reset = 1'b1;
        #2;
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        req_a = 1'b1;
        req_b = 1'b1;
`ifdef SCHED_COOLDOWN_EN
        // COOLDOWN=2: grants 3 cycles apart, alternating lanes
        tick();
        chk_d("cd1", 1'b1, 1'b0, 8'd1, 2'b01);
        tick();
        chk_d("cd1_gap1", 1'b0, 1'b0, 8'd1, 2'b01);
        tick();
        chk_d("cd1_gap2", 1'b0, 1'b0, 8'd1, 2'b01);
        tick();
        chk_d("cd2", 1'b0, 1'b1, 8'd2, 2'b01);
        tick();
        chk_d("cd2_gap1", 1'b0, 1'b0, 8'd2, 2'b01);
        tick();
        chk_d("cd2_gap2", 1'b0, 1'b0, 8'd2, 2'b01);
        tick();
        chk_d("cd3", 1'b1, 1'b0, 8'd3, 2'b01);
        req_a = 1'b0;
        req_b = 1'b0;
`else
        // back-to-back alternation; dut3 halts on its 3rd grant
        tick();
        chk_d("rr1", 1'b1, 1'b0, 8'd1, 2'b01);
        tick();
        chk_d("rr2", 1'b0, 1'b1, 8'd2, 2'b01);
        tick();
        chk_d("rr3", 1'b1, 1'b0, 8'd3, 2'b01);
        chk("h3.gnt_a", {7'd0, h_gnt_a}, 8'd1);
        chk("h3.en",    {7'd0, h_en},    8'd1);
        chk("h3.tc",    h_tc,            8'd3);
        chk("h3.state", {6'd0, h_st},    8'd2);
        chk("h3.halt",  {7'd0, h_halt},  8'd1);
        tick();
        chk_d("rr4", 1'b0, 1'b1, 8'd4, 2'b01);
        chk("h4.en",    {7'd0, h_en},    8'd0);
        chk("h4.tc",    h_tc,            8'd3);
        chk("h4.halt",  {7'd0, h_halt},  8'd1);
        // start must not leave HALTED
        start = 1'b1;
        tick();
        chk_d("rr5", 1'b1, 1'b0, 8'd5, 2'b01);
        chk("h5.gnt",   {6'd0, h_gnt_a, h_gnt_b}, 8'd0);
        chk("h5.tc",    h_tc,            8'd3);
        chk("h5.state", {6'd0, h_st},    8'd2);
        start = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;

        // async reset while gnt_a=1 and trade_count=5
        reset = 1'b1;
        #1;
        chk_d("async_rst", 1'b0, 1'b0, 8'd0, 2'b00);
        chk("async_rst.halt", {7'd0, d_halt}, 8'd0);
        chk("async_rst.h_halt", {7'd0, h_halt}, 8'd0);
        reset = 1'b0;
`endif
        tick();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/match_sched.md
# match_sched

Session controller and two-lane match arbiter for the trade counting path. It accepts match requests from two matcher lanes, lane A and lane B, and grants them round-robin as one-cycle pulses. It issues a matching `enable_count` pulse for the downstream trade counter and keeps its own 8-bit trade tally. A session FSM (IDLE/OPEN/HALTED/CLOSED) gates all grants and halts trading when the trade limit is reached.

## Interface
Parameters:
- `MAX_TRADES`, default 99: trade limit per session. Legal range is 1..255.
- `COOLDOWN`, default 2: number of idle cycles forced after each grant. Used only when `SCHED_COOLDOWN_EN` is defined. Legal range is 1..15.

Ports:
- `slow_clk`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  opens a session. Sampled as a level.
- `stop`  in  1  closes the session. Sampled as a level.
- `req_a`  in  1  lane A match request. Held high until granted.
- `req_b`  in  1  lane B match request. Held high until granted.
- `gnt_a`  out  1  one-cycle grant pulse to lane A. Registered.
- `gnt_b`  out  1  one-cycle grant pulse to lane B. Registered.
- `enable_count`  out  1  equals `gnt_a | gnt_b`. Registered.
- `trade_count`  out  8  trades granted in the current session.
- `halt_signal`  out  1  high while the FSM is in HALTED.
- `state`  out  2  FSM state: IDLE=00, OPEN=01, HALTED=10, CLOSED=11.

## Operation
- Reset values: `state`=IDLE, all grants=0, `enable_count`=0, `trade_count`=0, `halt_signal`=0, round-robin pointer=B (so lane A wins first), cooldown counter=0.
- IDLE:
  - `start` moves the FSM to OPEN.
  - `stop` is ignored.
- OPEN:
  - Arbitration and grants happen only in this state.
  - `stop` moves the FSM to CLOSED. `stop` has priority over a grant in the same cycle: no grant is issued.
- HALTED:
  - No grants are issued.
  - `start` is ignored.
  - `stop` moves the FSM to CLOSED.
  - `halt_signal` stays 1.
- CLOSED:
  - `start` moves the FSM to OPEN and clears `trade_count` to 0 on the same edge.
  - `halt_signal` clears on entry.
- Eligibility: a lane is eligible when its req=1 and it was not granted in the current cycle. Its gnt=1 marks its drop cycle, so the requester must deassert req during that cycle.
- Arbitration:
  - Only one lane eligible: that lane is granted.
  - Both lanes eligible: the lane not pointed to by the round-robin pointer is granted.
  - The pointer updates to the granted lane.
- Each grant:
  - `trade_count` increments by 1 on the same edge that raises gnt.
  - If the new value equals `MAX_TRADES`, the FSM moves to HALTED on that same edge.
  - `trade_count` never exceeds `MAX_TRADES` and never wraps.
- A request held across a transition out of OPEN is not granted. It is granted after re-entry to OPEN if it is still held.
- `reset` asserted at any time, including mid-grant, returns every output to its reset value immediately.

## Timing
- Request-to-grant latency is 1 cycle: a req sampled eligible at edge k gives gnt high from edge k to edge k+1.
- gnt and `enable_count` are exactly one cycle wide.
- Alternating lanes can be granted on back-to-back cycles.
- The same lane can be granted at most every 2nd cycle.
- `trade_count`, `state` and `halt_signal` update on the edge that raises the final gnt, so `halt_signal` is coincident with the last `enable_count` pulse.
- `start`/`stop` take effect at the next edge (one-cycle latency to `state`).

## Configuration
- `SCHED_COOLDOWN_EN` defined:
  - After each grant, the cooldown counter loads `COOLDOWN`.
  - No grant is issued while the counter is nonzero; it decrements once per cycle in OPEN.
  - The counter clears on leaving OPEN.
  - Minimum grant spacing is `COOLDOWN`+1 cycles.
- `SCHED_COOLDOWN_EN` undefined: no cooldown logic is built, and grant spacing follows only the eligibility rules.

## Test plan
- Reset, then `start`, then `req_a` held 1 cycle: `gnt_a` and `enable_count` are high for one cycle, 1 cycle after req; `trade_count`=1; `state`=01.
- `req_a` and `req_b` both held continuously, cooldown off: grants are A,B,A,B on consecutive cycles; `trade_count` increments by 1 each cycle.
- `MAX_TRADES`=3 with continuous requests: on the 3rd grant, `trade_count`=3, `state`=10 and `halt_signal`=1 on the same edge; no further grants; `trade_count` stays 3.
- `stop` and an eligible `req_b` in the same cycle in OPEN: no `gnt_b`; `state`=11. Then `start`: `trade_count`=0, `state`=01, and `gnt_b` follows on the next cycle.
- `SCHED_COOLDOWN_EN` defined, `COOLDOWN`=2, both lanes requesting continuously: grants are spaced exactly 3 cycles apart and alternate lanes.
- `reset` asserted while `gnt_a`=1 and `trade_count`=5: `gnt_a`=0, `trade_count`=0 and `state`=00 without waiting for a clock edge.
